// File: rtl/val2_shift_unit_if.sv
// Handshake and operand bundle for val2_shift_unit.
// master: the issuing EXE stage (drives request, flush and out_ready).
// slave : the shift unit (drives in_ready, out_valid, result, carry_out).
interface val2_shift_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rm_val;
  logic [7:0]       rs_val;
  logic             imm;
  logic             ld_or_str;
  logic [11:0]      shift_operand;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output flush, in_valid, rm_val, rs_val, imm, ld_or_str, shift_operand,
           carry_in, out_ready,
    input  in_ready, out_valid, result, carry_out
  );

  modport slave (
    input  flush, in_valid, rm_val, rs_val, imm, ld_or_str, shift_operand,
           carry_in, out_ready,
    output in_ready, out_valid, result, carry_out
  );
endinterface

// File: rtl/val2_shift_unit.sv
// Iterative Val2 operand generator: shifts STEP bit positions per cycle and
// produces the ALU second operand plus the shifter carry-out.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - val2_shift_unit_if.slave: request (in_valid/in_ready + operands),
//          flush, and result (out_valid/out_ready, result, carry_out)
module val2_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input logic              clk,
  input logic              rst,
  val2_shift_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned LW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_LSL = 2'b00, OP_LSR = 2'b01,
                            OP_ASR = 2'b10, OP_ROR = 2'b11} op_e;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    rem_q;
  logic             carry_q;
  logic             zero_co_q;

  // Accept-time decode: mode, effective amount, or a direct (N=0) result.
  logic [7:0]       amount;
  op_e              reg_op;
  logic             acc_direct;
  logic [WIDTH-1:0] acc_res;
  logic             acc_co;
  logic [WIDTH-1:0] acc_val;
  op_e              acc_op;
  logic [CW-1:0]    acc_rem;
  logic             acc_zero_co;

  always_comb begin
    amount      = bus.shift_operand[4] ? bus.rs_val : {3'b000, bus.shift_operand[11:7]};
    reg_op      = op_e'(bus.shift_operand[6:5]);
    acc_direct  = 1'b1;
    acc_res     = bus.rm_val;
    acc_co      = bus.carry_in;
    acc_val     = bus.rm_val;
    acc_op      = OP_ROR;
    acc_rem     = '0;
    acc_zero_co = 1'b0;
    if (bus.ld_or_str) begin
      acc_res = {{(WIDTH-12){bus.shift_operand[11]}}, bus.shift_operand};
    end else if (bus.imm) begin
      acc_res = {{(WIDTH-8){1'b0}}, bus.shift_operand[7:0]};
      if (bus.shift_operand[11:8] != 4'd0) begin
        acc_direct = 1'b0;
        acc_val    = {{(WIDTH-8){1'b0}}, bus.shift_operand[7:0]};
        acc_rem    = CW'({bus.shift_operand[11:8], 1'b0});
      end
    end else if (amount != 8'd0) begin
      if (reg_op == OP_ROR) begin
        // A non-zero multiple of WIDTH is a full rotation: value unchanged,
        // carry is the MSB.
        if (amount[LW-1:0] == '0) begin
          acc_co = bus.rm_val[WIDTH-1];
        end else begin
          acc_direct = 1'b0;
          acc_rem    = CW'(amount[LW-1:0]);
        end
      end else begin
        acc_direct = 1'b0;
        acc_op     = reg_op;
        // Over-range shifts saturate at WIDTH; LSL/LSR then drop the carry.
        if ({1'b0, amount} > 9'(WIDTH)) begin
          acc_rem     = CW'(WIDTH);
          acc_zero_co = (reg_op != OP_ASR);
        end else begin
          acc_rem = CW'(amount);
        end
      end
    end
  end

  // One iteration: shift by k = min(STEP, remaining), capture last bit out.
  logic [CW-1:0]    step_k;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;
  logic [WIDTH:0]   lsl_ext;
  logic [WIDTH:0]   lsr_ext;
  logic [WIDTH:0]   asr_ext;
  logic [WIDTH-1:0] ror_val;

  always_comb begin
    step_k   = (rem_q > CW'(STEP)) ? CW'(STEP) : rem_q;
    lsl_ext  = {1'b0, work_q} << step_k;
    lsr_ext  = {work_q, 1'b0} >> step_k;
    asr_ext  = $signed({work_q, 1'b0}) >>> step_k;
    ror_val  = (work_q >> step_k) | (work_q << (CW'(WIDTH) - step_k));
    step_val = work_q;
    step_bit = 1'b0;
    case (op_q)
      OP_LSL: begin step_val = lsl_ext[WIDTH-1:0]; step_bit = lsl_ext[WIDTH];   end
      OP_LSR: begin step_val = lsr_ext[WIDTH:1];   step_bit = lsr_ext[0];       end
      OP_ASR: begin step_val = asr_ext[WIDTH:1];   step_bit = asr_ext[0];       end
      default: begin step_val = ror_val;           step_bit = ror_val[WIDTH-1]; end
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_LSL;
      work_q    <= '0;
      result_q  <= '0;
      rem_q     <= '0;
      carry_q   <= 1'b0;
      zero_co_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush && bus.in_valid) begin
            if (acc_direct) begin
              result_q <= acc_res;
              carry_q  <= acc_co;
              state_q  <= DONE;
            end else begin
              work_q    <= acc_val;
              op_q      <= acc_op;
              rem_q     <= acc_rem;
              zero_co_q <= acc_zero_co;
              state_q   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (bus.flush) begin
            rem_q   <= '0;
            state_q <= IDLE;
          end else begin
            work_q <= step_val;
            rem_q  <= rem_q - step_k;
            if (rem_q == step_k) begin
              result_q <= step_val;
              carry_q  <= step_bit & ~zero_co_q;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.flush || bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;

endmodule
